// File: rtl/gba_sound_frame_seq.sv
// GBA APU frame sequencer: divides the ce strobe into the 512 Hz step clock and
// decodes length/sweep/envelope ticks, plus the mixer sample strobe.
module gba_sound_frame_seq #(
    parameter int STEP_CYCLES = 8192,
    parameter int SAMPLE_BASE = 512
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       gb_on,
    input  logic [1:0] resolution,
    output logic       length_tick,
    output logic       sweep_tick,
    output logic       envelope_tick,
    output logic       sample_tick,
    output logic [2:0] step,
    output logic       seq_running
);

    localparam int DIV_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int SMP_W = $clog2(SAMPLE_BASE + 1);

    logic [DIV_W-1:0] div_q;
    logic [2:0]       step_q;
    logic [SMP_W-1:0] samp_q;
    logic [SMP_W-1:0] samp_period;
    logic [1:0]       res_q;
    logic             step_tc;
    logic             samp_tc;
    logic             res_change;

    assign step = step_q;

    always_comb begin
        samp_period = SMP_W'(SAMPLE_BASE) >> resolution;
        res_change  = (resolution != res_q);
        step_tc     = ce && (div_q == DIV_W'(STEP_CYCLES - 1));
        samp_tc     = ce && !res_change && (samp_q == samp_period - SMP_W'(1));
    end

    // Step divider and tick decode; ticks describe the step being left.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q         <= '0;
            step_q        <= '0;
            length_tick   <= 1'b0;
            sweep_tick    <= 1'b0;
            envelope_tick <= 1'b0;
        end else begin
            length_tick   <= 1'b0;
            sweep_tick    <= 1'b0;
            envelope_tick <= 1'b0;
            if (!gb_on) begin
                div_q  <= '0;
                step_q <= '0;
            end else if (step_tc) begin
                div_q         <= '0;
                step_q        <= step_q + 3'd1;
                length_tick   <= ~step_q[0];
                sweep_tick    <= (step_q[1:0] == 2'b10);
                envelope_tick <= (step_q == 3'd7);
            end else if (ce) begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    // A resolution change restarts the sample period from zero without a strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            samp_q      <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= 1'b0;
            if (!gb_on || res_change) begin
                samp_q <= '0;
            end else if (samp_tc) begin
                samp_q      <= '0;
                sample_tick <= 1'b1;
            end else if (ce) begin
                samp_q <= samp_q + SMP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_q       <= '0;
            seq_running <= 1'b0;
        end else begin
            res_q       <= resolution;
            seq_running <= gb_on;
        end
    end

endmodule

// File: tb/tb_gba_sound_frame_seq.sv
// Scoreboard bench for gba_sound_frame_seq using scaled periods
// (STEP_CYCLES=64, SAMPLE_BASE=32) so every scenario fits in a short run.
module tb_gba_sound_frame_seq;

    localparam int S  = 64;
    localparam int SB = 32;

    logic       clk;
    logic       reset_n;
    logic       ce;
    logic       gb_on;
    logic [1:0] resolution;
    logic       length_tick;
    logic       sweep_tick;
    logic       envelope_tick;
    logic       sample_tick;
    logic [2:0] step;
    logic       seq_running;
    logic [3:0] tk;

    gba_sound_frame_seq #(.STEP_CYCLES(S), .SAMPLE_BASE(SB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ce           (ce),
        .gb_on        (gb_on),
        .resolution   (resolution),
        .length_tick  (length_tick),
        .sweep_tick   (sweep_tick),
        .envelope_tick(envelope_tick),
        .sample_tick  (sample_tick),
        .step         (step),
        .seq_running  (seq_running)
    );

    assign tk = {length_tick, sweep_tick, envelope_tick, sample_tick};

    typedef struct {
        int         cyc;
        logic [3:0] ticks;
    } ev_t;

    ev_t exp_q[$];
    ev_t ev;
    int  cyc;
    int  n_cmp;
    int  n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tick vector {length, sweep, envelope, 0} for the n-th ce after gb_on rise.
    function automatic logic [3:0] step_ticks(int n);
        logic [3:0] t;
        int lv;
        t = 4'b0;
        if (n % S == 0) begin
            lv   = ((n / S) - 1) % 8;
            t[3] = (lv % 2 == 0);
            t[2] = (lv == 2) || (lv == 6);
            t[1] = (lv == 7);
        end
        return t;
    endfunction

    // Expected events for n_ce ce pulses, one every per clks, starting at edge base+1.
    function automatic void push_run(int base, int n_ce, int per, int res);
        int p;
        logic [3:0] t;
        p = SB >> res;
        for (int n = 1; n <= n_ce; n++) begin
            t = step_ticks(n);
            if (n % p == 0) t[0] = 1'b1;
            if (t != 4'b0) exp_q.push_back('{base + (n - 1) * per + 1, t});
        end
    endfunction

    task automatic drive_run(int edges, int per);
        for (int j = 1; j <= edges; j++) begin
            ce = ((j - 1) % per == 0);
            @(negedge clk);
        end
    endtask

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every tick must match the head of the expected queue on its cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_tick: cyc %0d got none, want %b", exp_q[0].cyc, exp_q[0].ticks);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            ev = exp_q.pop_front();
            n_cmp++;
            if (tk !== ev.ticks) begin
                n_bad++;
                $display("FAIL tick_vec: cyc %0d got %b, want %b", cyc, tk, ev.ticks);
            end
        end else if (tk !== 4'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_tick: cyc %0d got %b, want 0000", cyc, tk);
        end
    end

    initial begin
        int base;
        int c;
        logic [3:0] t;
        n_cmp      = 0;
        n_bad      = 0;
        reset_n    = 1'b1;
        ce         = 1'b0;
        gb_on      = 1'b0;
        resolution = 2'd0;
        #1 reset_n = 1'b0;
        #1;
        check("reset_step", int'(step), 0);
        check("reset_running", int'(seq_running), 0);
        check("reset_ticks", int'(tk), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_step", int'(step), 0);
        check("idle_running", int'(seq_running), 0);

        // Continuous ce, resolution 0, two full sequences.
        gb_on = 1'b1;
        base  = cyc;
        push_run(base, 16 * S, 1, 0);
        drive_run(3 * S, 1);
        check("a_step3", int'(step), 3);
        check("a_running", int'(seq_running), 1);
        drive_run(13 * S, 1);
        check("a_step_wrap", int'(step), 0);
        gb_on = 1'b0;
        @(negedge clk);
        check("a_off_step", int'(step), 0);
        check("a_off_running", int'(seq_running), 0);
        resolution = 2'd1;
        @(negedge clk);

        // ce one clk in four, resolution 1.
        gb_on = 1'b1;
        base  = cyc;
        push_run(base, 8 * S, 4, 1);
        drive_run(2 * S * 4, 4);
        check("b_step2", int'(step), 2);
        drive_run(6 * S * 4, 4);
        check("b_step_wrap", int'(step), 0);
        gb_on      = 1'b0;
        resolution = 2'd0;
        repeat (2) @(negedge clk);

        // gb_on dropped at step 5 for 10 clks, then a fresh sequence.
        gb_on = 1'b1;
        base  = cyc;
        push_run(base, 5 * S + 20, 1, 0);
        drive_run(5 * S + 20, 1);
        check("c_step5", int'(step), 5);
        gb_on = 1'b0;
        ce    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("c_low_step", int'(step), 0);
        end
        gb_on = 1'b1;
        base  = cyc;
        push_run(base, 8 * S, 1, 0);
        drive_run(8 * S, 1);
        check("c_step_wrap", int'(step), 0);
        gb_on = 1'b0;
        repeat (2) @(negedge clk);

        // Resolution 0 -> 3 when the count equals the new P-1: no strobe on the switch.
        gb_on = 1'b1;
        base  = cyc;
        drive_run(3, 1);
        resolution = 2'd3;
        for (int n = 4; n <= 140; n++) begin
            t = step_ticks(n);
            if (n > 4 && (n - 4) % 4 == 0) t[0] = 1'b1;
            if (t != 4'b0) exp_q.push_back('{base + n, t});
        end
        drive_run(137, 1);
        check("d_step2", int'(step), 2);
        gb_on      = 1'b0;
        resolution = 2'd0;
        repeat (2) @(negedge clk);

        // Asynchronous reset pulse in step 6.
        gb_on = 1'b1;
        base  = cyc;
        push_run(base, 6 * S + 10, 1, 0);
        drive_run(6 * S + 10, 1);
        check("e_step6", int'(step), 6);
        c = cyc;
        #1 reset_n = 1'b0;
        #1;
        check("e_rst_step", int'(step), 0);
        check("e_rst_running", int'(seq_running), 0);
        check("e_rst_ticks", int'(tk), 0);
        push_run(c, 2 * S, 1, 0);
        #2 reset_n = 1'b1;
        @(negedge clk);
        drive_run(2 * S - 1, 1);
        check("e_step2", int'(step), 2);
        gb_on = 1'b0;
        repeat (2) @(negedge clk);

        // gb_on falls on the step 7 terminal edge.
        gb_on = 1'b1;
        base  = cyc;
        push_run(base, 8 * S - 1, 1, 0);
        drive_run(8 * S - 1, 1);
        check("f_step7", int'(step), 7);
        gb_on = 1'b0;
        ce    = 1'b1;
        @(negedge clk);
        check("f_step0", int'(step), 0);
        check("f_running", int'(seq_running), 0);
        repeat (3) @(negedge clk);

        while (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_tick: cyc %0d got none, want %b", exp_q[0].cyc, exp_q[0].ticks);
            void'(exp_q.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gba_sound_frame_seq.md
GBA_SOUND_FRAME_SEQ -- requirements
Module: gba_sound_frame_seq

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 8192, meaning ce cycles per frame-sequencer step.
REQ-002 SHALL have parameter SAMPLE_BASE, default 512, meaning ce cycles per mixer sample at resolution 0.
REQ-003 SHALL have port clk  input  1  single clock for all state.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ce  input  1  cycle-enable strobe; counters advance only on clk edges with ce=1.
REQ-006 SHALL have port gb_on  input  1  sound master enable (SOUNDCNT_X bit 7).
REQ-007 SHALL have port resolution  input  2  SOUNDBIAS sampling-cycle select.
REQ-008 SHALL have port length_tick  output  1  one-clk pulse that clocks the length counters of channels 1-4.
REQ-009 SHALL have port sweep_tick  output  1  one-clk pulse that clocks the channel 1 sweep.
REQ-010 SHALL have port envelope_tick  output  1  one-clk pulse that clocks the envelopes of channels 1, 2 and 4.
REQ-011 SHALL have port sample_tick  output  1  one-clk pulse that strobes the mixer and FIFO sample output.
REQ-012 SHALL have port step  output  3  current sequencer step, 0-7.
REQ-013 SHALL have port seq_running  output  1  registered copy of gb_on.

Function
REQ-014 SHALL hold a step divider, ceil(log2(STEP_CYCLES)) bits wide, that increments on ce while gb_on=1.
REQ-015 Terminal count is divider=STEP_CYCLES-1 with ce=1; on that edge the divider SHALL wrap to 0 and step SHALL advance modulo 8 (7 wraps to 0).
REQ-016 At terminal count the ticks SHALL decode the step being left: length_tick for steps 0, 2, 4 and 6; sweep_tick for steps 2 and 6; envelope_tick for step 7.
REQ-017 Ticks SHALL be registered and SHALL be high for exactly one clk; they SHALL be low on every other edge, including when ce stays high.
REQ-018 Resulting periods, in ce cycles: length 16384, sweep 32768, envelope 65536; the full sequence SHALL repeat every 8*STEP_CYCLES.
REQ-019 The sample counter SHALL count ce cycles; period P = SAMPLE_BASE >> resolution (512/256/128/64).
REQ-020 When count=P-1 with ce=1, sample_tick SHALL pulse for one clk and the count SHALL wrap to 0.
REQ-021 The block SHALL register resolution each clk; when the input differs from the registered value, the sample counter SHALL clear to 0, no sample_tick SHALL be issued on that edge, and counting SHALL restart under the new P.
REQ-022 While gb_on=0, the following SHALL be held at 0 synchronously: divider, step, sample counter, all ticks.
REQ-023 After gb_on rises, the sequence SHALL begin at step 0 with divider 0; the first length_tick SHALL occur at the STEP_CYCLES-th ce.
REQ-024 A gb_on fall SHALL take priority over a simultaneous terminal count: no tick is issued and state clears.
REQ-025 When sample and step terminal counts fall on the same edge, both pulses SHALL be issued on that edge.
REQ-026 While ce=0, all counters and step SHALL hold, and ticks SHALL be 0.
REQ-027 seq_running SHALL follow gb_on with one clk latency.

Reset
REQ-028 When reset_n=0, the block SHALL immediately (asynchronously) clear divider, step, sample counter, registered resolution, all ticks and seq_running.
REQ-029 Release of reset_n SHALL take effect on the next clk edge; behaviour is then as if gb_on had just risen, when gb_on=1.
REQ-030 Asserting reset_n mid-step SHALL discard the partial count with no tick emitted.

Verification
REQ-031 Scenario: gb_on=1, ce=1 constant, resolution 0 -> length_tick at ce 8192, 24576, 40960 and 57344; sweep_tick at 24576 and 57344; envelope_tick at 65536; the pattern repeats at +65536; sample_tick every 512.
REQ-032 Scenario: ce asserted 1 clk in 4 -> every tick position from REQ-031 occurs at 4x the clk count; each tick is still exactly 1 clk wide.
REQ-033 Scenario: gb_on dropped at step 5, divider 1000, then raised 10 clk later -> outputs are 0 and step=0 while low; after the rise, the REQ-031 timing repeats exactly from that point.
REQ-034 Scenario: resolution 0, sample count 300, switched to 3 -> no pulse on the switch edge; next sample_tick 64 ce later, then every 64.
REQ-035 Scenario: reset_n pulsed low for half a clk at step 6 -> all outputs 0 at once without waiting for clk; after release, the first length_tick arrives at the 8192nd ce.
REQ-036 Scenario: gb_on falls on the same edge as the step 7 terminal count -> no envelope_tick; step reads 0.
